node_injector: RTL and testbench
================================

// Module: node_injector
// PURPOSE
//   Transmit side of a ring node: accepts payloads from the local host, builds the 32-bit
//   instruction {dest[31:29], origin[28:26], payload[25:0]} and injects it into the
//   node_controller as a local packet (source_port 2'b10).
//   Transit ring traffic has priority. The block buffers packets and arbitrates for an idle slot.
//   It flags starvation when transit traffic blocks injection for too long.
// PARAMETERS
//   NODE_IP          3'b000  this node's address; written into origin field
//   NODE_IP_BITWIDTH 3       address field width (header = 2*NODE_IP_BITWIDTH bits)
//   FIFO_DEPTH       4       injection buffer entries; power of 2, >=2
//   STARVE_LIMIT     16      consecutive blocked cycles before starve asserts; 1..255
// PORTS
//   clk            in   1   single clock, rising edge
//   rst_n          in   1   asynchronous active-low reset
//   host_valid     in   1   host offers a packet
//   host_ready     out  1   buffer can accept (= !full)
//   host_dest      in   3   destination node address
//   host_payload   in   26  payload bits
//   ring_busy      in   1   transit packet occupies node_controller this cycle
//   tx_valid       out  1   local instruction presented
//   tx_ready       in   1   node_controller/link accepts tx_instruction
//   tx_instruction out  32  formatted instruction; 0 when !tx_valid
//   tx_source_port out  2   2'b10 when tx_valid, else 2'b11 (no local packet)
//   starve         out  1   injection blocked >= STARVE_LIMIT cycles
//   tx_count       out  8   accepted-packet counter, wraps 255->0
// BEHAVIOUR
//   - Reset (async, any cycle, mid-transfer included): FIFO emptied; state IDLE; tx_valid=0;
//     tx_instruction=0; tx_source_port=2'b11; starve=0; starve counter=0; tx_count=0;
//     host_ready=1 from the first clock after release. Any packet in flight is discarded.
//   - Push: host_valid & host_ready at an edge writes {host_dest, NODE_IP, host_payload}.
//     No bypass: an entry is visible to the FSM one cycle after it is written.
//   - Pop: tx_valid & tx_ready at an edge removes the head. Push and pop in the same cycle
//     leave the occupancy unchanged.
//   - host_ready is combinational from registered occupancy: a full FIFO refuses a push
//     even while a pop happens in the same cycle.
//   - FSM (registered; tx_valid = state==SEND):
//     IDLE: occupancy 0. Next is SEND if occupancy>0 and !ring_busy.
//       Next is WAIT if occupancy>0 and ring_busy.
//     WAIT: increments the starve counter, which saturates at STARVE_LIMIT.
//       starve = (counter==STARVE_LIMIT). Next is SEND when !ring_busy.
//       Leaving WAIT clears the counter and starve.
//     SEND: the head is held stable until tx_ready; ring_busy is ignored once SEND is entered.
//       On handshake: stay SEND if occupancy after pop >0 and !ring_busy
//       (back-to-back, 1 pkt/cycle).
//       Otherwise go to WAIT if occupancy>0, else IDLE.
//   - Latency: host push at edge N -> tx_valid high after edge N+2 (idle ring, empty FIFO).
//   - dest==NODE_IP (loopback) is injected normally; node_controller returns it locally.
//   - tx_count increments on every tx handshake; 8-bit wrap.
//   - Pointers are log2(FIFO_DEPTH) bits with natural wrap. Occupancy is log2(FIFO_DEPTH)+1 bits.
// STRUCTURE
//   - Shared package node_pkg:
//     - NODE_IP_BITWIDTH
//     - header field offsets (DEST_MSB=31, ORIG_MSB=28, PAYLOAD_W=26)
//     - SRC_PORT_CW=2'b00, SRC_PORT_CCW=2'b01, SRC_PORT_LOCAL=2'b10, SRC_PORT_IDLE=2'b11
//     - state encoding IDLE/WAIT/SEND
//   - Sub-module node_tx_fifo: synchronous FIFO (push/pop/full/empty/count, async reset).
//   - FSM, starve counter and tx_count stay in node_injector.
// TESTING
//   1 Reset/idle: rst_n=0 mid-SEND with 2 queued -> next cycle tx_valid=0, tx_source_port=2'b11,
//     host_ready=1, tx_count=0.
//   2 Format: NODE_IP=3'b010, push dest=3'b101 payload=26'h0ABCDEF, ring_busy=0, tx_ready=1
//     -> tx_instruction=32'hA8ABCDEF at cycle N+2, tx_count=1.
//   3 Full/backpressure: tx_ready=0, push 5 packets -> 4 accepted, host_ready=0 after 4th;
//     1 pop plus simultaneous push with full FIFO -> push refused, occupancy 3.
//   4 Priority/starve: queue 1, ring_busy=1 for 20 cycles -> tx_valid=0, starve=1 from 16th WAIT
//     cycle; ring_busy=0 -> SEND next cycle, starve=0.
//   5 Hold: in SEND, raise ring_busy and hold tx_ready=0 for 3 cycles -> tx_instruction stable,
//     tx_valid=1; tx_ready=1 -> popped.
//   6 Throughput/wrap: stream 300 packets, ring_busy=0, tx_ready=1 -> one handshake per cycle
//     after fill; tx_count=44 (300 mod 256), order preserved.

Source files
------------

// File: rtl/node_pkg.sv
// Shared definitions for the ring-node transmit path.
// Contents: address/field widths, instruction field offsets, source-port
// codes, injector state encoding and the instruction formatter.
package node_pkg;

  localparam int NODE_IP_BITWIDTH = 3;
  localparam int DEST_MSB         = 31;
  localparam int ORIG_MSB         = 28;
  localparam int PAYLOAD_W        = 26;
  localparam int INSTR_W          = 32;

  localparam logic [1:0] SRC_PORT_CW    = 2'b00;
  localparam logic [1:0] SRC_PORT_CCW   = 2'b01;
  localparam logic [1:0] SRC_PORT_LOCAL = 2'b10;
  localparam logic [1:0] SRC_PORT_IDLE  = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    SEND = 2'd2
  } inj_state_e;

  // {dest[31:29], origin[28:26], payload[25:0]}
  function automatic logic [INSTR_W-1:0] build_instr(
    input logic [NODE_IP_BITWIDTH-1:0] dest,
    input logic [NODE_IP_BITWIDTH-1:0] origin,
    input logic [PAYLOAD_W-1:0]        payload
  );
    logic [INSTR_W-1:0] instr;
    instr = '0;
    instr[DEST_MSB -: NODE_IP_BITWIDTH] = dest;
    instr[ORIG_MSB -: NODE_IP_BITWIDTH] = origin;
    instr[PAYLOAD_W-1:0]                = payload;
    return instr;
  endfunction

endpackage

// File: rtl/node_injector_if.sv
// Host / ring / link signal bundle of the node injector.
// master: host + node_controller side (drives requests, ring_busy, tx_ready)
// slave : the injector (drives host_ready, tx_*, starve, tx_count)
interface node_injector_if;
  import node_pkg::*;

  logic                        host_valid;
  logic                        host_ready;
  logic [NODE_IP_BITWIDTH-1:0] host_dest;
  logic [PAYLOAD_W-1:0]        host_payload;
  logic                        ring_busy;
  logic                        tx_valid;
  logic                        tx_ready;
  logic [INSTR_W-1:0]          tx_instruction;
  logic [1:0]                  tx_source_port;
  logic                        starve;
  logic [7:0]                  tx_count;

  modport master (
    output host_valid, host_dest, host_payload, ring_busy, tx_ready,
    input  host_ready, tx_valid, tx_instruction, tx_source_port, starve, tx_count
  );

  modport slave (
    input  host_valid, host_dest, host_payload, ring_busy, tx_ready,
    output host_ready, tx_valid, tx_instruction, tx_source_port, starve, tx_count
  );

endinterface

// File: rtl/node_tx_fifo.sv
// Synchronous injection buffer with asynchronous active-low reset.
// Ports: clk, rst_n; push_i/data_i write side; pop_i/data_o read side
// (data_o is the head entry); full_o, empty_o, count_o occupancy status.
// Pushes into a full FIFO and pops from an empty one are ignored.
module node_tx_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 32
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         data_i,
  input  logic                     pop_i,
  output logic [WIDTH-1:0]         data_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic             push_ok, pop_ok;

  assign full_o  = (count_q == (AW+1)'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign data_o  = mem_q[rd_ptr_q];

  assign push_ok = push_i & ~full_o;
  assign pop_ok  = pop_i & ~empty_o;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop_ok)  rd_ptr_d = rd_ptr_q + 1'b1;
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: entries are only read once the count covers them.
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= data_i;
  end

endmodule

// File: rtl/node_injector.sv
// Transmit side of a ring node. Formats host payloads into 32-bit ring
// instructions, buffers them, and injects them as local packets whenever
// the node_controller is not carrying transit traffic.
// Ports: clk, rst_n (async, active low); bus (node_injector_if.slave):
//   host_valid/host_ready/host_dest/host_payload  host push side
//   ring_busy                                      transit occupancy
//   tx_valid/tx_ready/tx_instruction/tx_source_port local injection
//   starve                                         injection blocked too long
//   tx_count                                       accepted packets, mod 256
//
// state | meaning
// IDLE  | no visible packet buffered
// WAIT  | packet visible but transit traffic holds the slot; starve counter runs
// SEND  | head presented on tx_*, held until tx_ready
module node_injector
  import node_pkg::*;
#(
  parameter logic [NODE_IP_BITWIDTH-1:0] NODE_IP = '0,
  parameter int FIFO_DEPTH   = 4,
  parameter int STARVE_LIMIT = 16
) (
  input logic            clk,
  input logic            rst_n,
  node_injector_if.slave bus
);

  localparam int         AW         = $clog2(FIFO_DEPTH);
  localparam logic [7:0] STARVE_MAX = 8'(STARVE_LIMIT);

  inj_state_e         state_q, state_d;
  logic [7:0]         starve_cnt_q, starve_cnt_d;
  logic [7:0]         tx_count_q, tx_count_d;
  logic               push_q;
  logic               fifo_full, fifo_empty;
  logic [AW:0]        fifo_count, vis_count, vis_after_pop;
  logic [INSTR_W-1:0] fifo_head, fifo_wdata;
  logic               push, pop, tx_valid;

  assign push       = bus.host_valid & ~fifo_full;
  assign pop        = tx_valid & bus.tx_ready;
  assign fifo_wdata = build_instr(bus.host_dest, NODE_IP, bus.host_payload);

  node_tx_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (INSTR_W)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (push),
    .data_i  (fifo_wdata),
    .pop_i   (pop),
    .data_o  (fifo_head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  // The entry written at the last edge is hidden from the FSM for one cycle,
  // so a push at edge N turns into tx_valid only after edge N+2.
  assign vis_count     = fifo_empty ? '0 : (fifo_count - {{AW{1'b0}}, push_q});
  assign vis_after_pop = vis_count - {{AW{1'b0}}, 1'b1};

  assign tx_valid = (state_q == SEND);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      starve_cnt_q <= '0;
      tx_count_q   <= '0;
      push_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      starve_cnt_q <= starve_cnt_d;
      tx_count_q   <= tx_count_d;
      push_q       <= push;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (vis_count != '0) state_d = bus.ring_busy ? WAIT : SEND;
      end
      WAIT: begin
        if (!bus.ring_busy) state_d = SEND;
      end
      SEND: begin
        // ring_busy only matters once the current head has gone.
        if (bus.tx_ready) begin
          if (vis_after_pop == '0)  state_d = IDLE;
          else if (bus.ring_busy)   state_d = WAIT;
          else                      state_d = SEND;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Counting the cycle that enters WAIT makes starve rise in the
  // STARVE_LIMIT-th WAIT cycle.
  always_comb begin
    starve_cnt_d = '0;
    if (state_d == WAIT) begin
      starve_cnt_d = (starve_cnt_q == STARVE_MAX) ? starve_cnt_q : starve_cnt_q + 8'd1;
    end
  end

  always_comb begin
    tx_count_d = tx_count_q;
    if (pop) tx_count_d = tx_count_q + 8'd1;
  end

  always_comb begin
    bus.tx_valid       = tx_valid;
    bus.tx_instruction = '0;
    bus.tx_source_port = SRC_PORT_IDLE;
    if (tx_valid) begin
      bus.tx_instruction = fifo_head;
      bus.tx_source_port = SRC_PORT_LOCAL;
    end
  end

  assign bus.host_ready = ~fifo_full;
  assign bus.starve     = (starve_cnt_q == STARVE_MAX);
  assign bus.tx_count   = tx_count_q;

endmodule

// File: tb/tb_node_injector.sv
module tb_node_injector;

  localparam logic [2:0] MY_IP = 3'b010;
  localparam int         DEPTH = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  node_injector_if bus();

  node_injector #(
    .NODE_IP      (MY_IP),
    .FIFO_DEPTH   (DEPTH),
    .STARVE_LIMIT (16)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int hs_total = 0;
  bit pop_now = 1'b0;

  // Reference: packets the host has handed over (in order), and the
  // expected/observed sequences of injected instructions.
  logic [31:0] exp_fifo[$];
  logic [31:0] exp_out[$];
  logic [31:0] obs_out[$];

  function automatic logic [31:0] fmt(input logic [2:0] d, input logic [25:0] p);
    return {d, MY_IP, p};
  endfunction

  task automatic clear_model();
    exp_fifo.delete();
    exp_out.delete();
    obs_out.delete();
  endtask

  task automatic tick();
    logic do_push, do_pop;
    logic [31:0] ins, wr;
    do_push = bus.host_valid && bus.host_ready;
    do_pop  = bus.tx_valid && bus.tx_ready;
    ins     = bus.tx_instruction;
    wr      = fmt(bus.host_dest, bus.host_payload);
    @(posedge clk); #1;
    cyc++;
    pop_now = do_pop;
    if (do_pop) begin
      obs_out.push_back(ins);
      hs_total++;
      if (exp_fifo.size() > 0) exp_out.push_back(exp_fifo.pop_front());
      else exp_out.push_back(32'hxxxx_xxxx);
    end
    if (do_push) exp_fifo.push_back(wr);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    bus.host_valid   = 1'b0;
    bus.host_dest    = '0;
    bus.host_payload = '0;
    bus.ring_busy    = 1'b0;
    bus.tx_ready     = 1'b0;
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    @(posedge clk); #1;
    clear_model();
    hs_total = 0;
  endtask

  task automatic rand_host();
    bus.host_dest    = 3'($urandom_range(0, 7));
    bus.host_payload = 26'($urandom);
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (bus.tx_valid !== 1'b0) begin errors++; $display("FAIL rst_tx_valid got %b exp 0", bus.tx_valid); end
    checks++; if (bus.tx_source_port !== 2'b11) begin errors++; $display("FAIL rst_src_port got %b exp 11", bus.tx_source_port); end
    checks++; if (bus.tx_instruction !== 32'h0) begin errors++; $display("FAIL rst_instr got %h exp 0", bus.tx_instruction); end
    checks++; if (bus.host_ready !== 1'b1) begin errors++; $display("FAIL rst_host_ready got %b exp 1", bus.host_ready); end
    checks++; if (bus.tx_count !== 8'd0) begin errors++; $display("FAIL rst_tx_count got %0d exp 0", bus.tx_count); end
    checks++; if (bus.starve !== 1'b0) begin errors++; $display("FAIL rst_starve got %b exp 0", bus.starve); end
  endtask

  task automatic test_format();
    bus.ring_busy    = 1'b0;
    bus.tx_ready     = 1'b1;
    bus.host_valid   = 1'b1;
    bus.host_dest    = 3'b101;
    bus.host_payload = 26'h0ABCDEF;
    tick();
    bus.host_valid = 1'b0;
    checks++; if (bus.tx_valid !== 1'b0) begin errors++; $display("FAIL fmt_lat_n got %b exp 0", bus.tx_valid); end
    tick();
    checks++; if (bus.tx_valid !== 1'b0) begin errors++; $display("FAIL fmt_lat_n1 got %b exp 0", bus.tx_valid); end
    tick();
    checks++; if (bus.tx_valid !== 1'b1) begin errors++; $display("FAIL fmt_lat_n2 got %b exp 1", bus.tx_valid); end
    checks++; if (bus.tx_instruction !== 32'hA8ABCDEF) begin errors++; $display("FAIL fmt_instr got %h exp a8abcdef", bus.tx_instruction); end
    checks++; if (bus.tx_source_port !== 2'b10) begin errors++; $display("FAIL fmt_src_port got %b exp 10", bus.tx_source_port); end
    tick();
    checks++; if (bus.tx_count !== 8'd1) begin errors++; $display("FAIL fmt_tx_count got %0d exp 1", bus.tx_count); end
    checks++; if (bus.tx_valid !== 1'b0) begin errors++; $display("FAIL fmt_after_pop got %b exp 0", bus.tx_valid); end
    checks++; if (obs_out.size() != 1 || obs_out[0] !== 32'hA8ABCDEF) begin errors++; $display("FAIL fmt_popped got %0d pkts exp 1 of a8abcdef", obs_out.size()); end
    clear_model();
  endtask

  task automatic test_reset_mid();
    int bad;
    bus.ring_busy = 1'b0;
    bus.tx_ready  = 1'b0;
    for (int i = 0; i < 2; i++) begin
      bus.host_valid = 1'b1;
      rand_host();
      tick();
    end
    bus.host_valid = 1'b0;
    for (int i = 0; i < 10 && bus.tx_valid !== 1'b1; i++) tick();
    checks++; if (bus.tx_valid !== 1'b1) begin errors++; $display("FAIL rmid_reach_send got %b exp 1", bus.tx_valid); end
    #2 rst_n = 1'b0;
    #1;
    checks++; if (bus.tx_valid !== 1'b0) begin errors++; $display("FAIL rmid_tx_valid got %b exp 0", bus.tx_valid); end
    checks++; if (bus.tx_source_port !== 2'b11) begin errors++; $display("FAIL rmid_src_port got %b exp 11", bus.tx_source_port); end
    checks++; if (bus.tx_instruction !== 32'h0) begin errors++; $display("FAIL rmid_instr got %h exp 0", bus.tx_instruction); end
    checks++; if (bus.tx_count !== 8'd0) begin errors++; $display("FAIL rmid_tx_count got %0d exp 0", bus.tx_count); end
    @(posedge clk); #1;
    checks++; if (bus.host_ready !== 1'b1) begin errors++; $display("FAIL rmid_host_ready got %b exp 1", bus.host_ready); end
    #2 rst_n = 1'b1;
    clear_model();
    hs_total = 0;
    bus.tx_ready = 1'b1;
    bad = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (bus.tx_valid !== 1'b0 || bus.host_ready !== 1'b1) bad++;
    end
    checks++; if (bad != 0) begin errors++; $display("FAIL rmid_discard got %0d bad cycles exp 0", bad); end
    clear_model();
  endtask

  task automatic test_full();
    int acc;
    bus.ring_busy  = 1'b0;
    bus.tx_ready   = 1'b0;
    acc = 0;
    for (int i = 0; i < 5; i++) begin
      bus.host_valid = 1'b1;
      rand_host();
      checks++; if (bus.host_ready !== (exp_fifo.size() < DEPTH)) begin errors++; $display("FAIL full_ready[%0d] got %b exp %b", i, bus.host_ready, exp_fifo.size() < DEPTH); end
      if (bus.host_ready === 1'b1) acc++;
      tick();
    end
    bus.host_valid = 1'b0;
    checks++; if (acc != 4) begin errors++; $display("FAIL full_accepted got %0d exp 4", acc); end
    checks++; if (bus.host_ready !== 1'b0) begin errors++; $display("FAIL full_ready_low got %b exp 0", bus.host_ready); end
    checks++; if (bus.tx_valid !== 1'b1) begin errors++; $display("FAIL full_held_send got %b exp 1", bus.tx_valid); end
    bus.tx_ready   = 1'b1;
    bus.host_valid = 1'b1;
    rand_host();
    tick();
    bus.host_valid = 1'b0;
    checks++; if (bus.host_ready !== 1'b1) begin errors++; $display("FAIL full_after_pop_ready got %b exp 1", bus.host_ready); end
    for (int i = 0; i < 20 && bus.tx_valid === 1'b1; i++) tick();
    checks++; if (obs_out.size() != 4) begin errors++; $display("FAIL full_drain_count got %0d exp 4", obs_out.size()); end
    for (int i = 0; i < obs_out.size(); i++) begin
      checks++; if (obs_out[i] !== exp_out[i]) begin errors++; $display("FAIL full_order[%0d] got %h exp %h", i, obs_out[i], exp_out[i]); end
    end
    clear_model();
  endtask

  task automatic test_starve();
    bus.ring_busy  = 1'b1;
    bus.tx_ready   = 1'b1;
    bus.host_valid = 1'b1;
    rand_host();
    tick();
    bus.host_valid = 1'b0;
    tick();
    for (int k = 1; k <= 20; k++) begin
      tick();
      checks++; if (bus.tx_valid !== 1'b0) begin errors++; $display("FAIL starve_blocked[%0d] got %b exp 0", k, bus.tx_valid); end
      checks++; if (bus.starve !== (k >= 16)) begin errors++; $display("FAIL starve_flag[%0d] got %b exp %b", k, bus.starve, k >= 16); end
    end
    bus.ring_busy = 1'b0;
    tick();
    checks++; if (bus.tx_valid !== 1'b1) begin errors++; $display("FAIL starve_release_send got %b exp 1", bus.tx_valid); end
    checks++; if (bus.starve !== 1'b0) begin errors++; $display("FAIL starve_release_clear got %b exp 0", bus.starve); end
    tick();
    checks++; if (obs_out.size() != 1 || obs_out[0] !== exp_out[0]) begin errors++; $display("FAIL starve_pkt got %0d pkts exp 1 matching", obs_out.size()); end
    clear_model();
  endtask

  task automatic test_hold();
    bus.ring_busy  = 1'b0;
    bus.tx_ready   = 1'b0;
    bus.host_valid = 1'b1;
    rand_host();
    tick();
    bus.host_valid = 1'b0;
    for (int i = 0; i < 10 && bus.tx_valid !== 1'b1; i++) tick();
    bus.ring_busy = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++; if (bus.tx_valid !== 1'b1) begin errors++; $display("FAIL hold_valid[%0d] got %b exp 1", i, bus.tx_valid); end
      checks++; if (exp_fifo.size() == 0 || bus.tx_instruction !== exp_fifo[0]) begin errors++; $display("FAIL hold_instr[%0d] got %h exp queued head", i, bus.tx_instruction); end
    end
    bus.tx_ready = 1'b1;
    tick();
    checks++; if (bus.tx_valid !== 1'b0) begin errors++; $display("FAIL hold_popped got %b exp 0", bus.tx_valid); end
    checks++; if (obs_out.size() != 1 || obs_out[0] !== exp_out[0]) begin errors++; $display("FAIL hold_pkt got %0d pkts exp 1 matching", obs_out.size()); end
    bus.ring_busy = 1'b0;
    clear_model();
  endtask

  task automatic test_throughput();
    int sent, first, last, bad;
    do_reset();
    bus.ring_busy = 1'b0;
    bus.tx_ready  = 1'b1;
    sent = 0; first = -1; last = -1;
    for (int c = 0; c < 500 && (sent < 300 || bus.tx_valid === 1'b1 || exp_fifo.size() > 0); c++) begin
      bus.host_valid = (sent < 300);
      rand_host();
      if (bus.host_valid && bus.host_ready === 1'b1) sent++;
      tick();
      if (pop_now) begin
        if (first < 0) first = cyc;
        last = cyc;
      end
    end
    bus.host_valid = 1'b0;
    checks++; if (sent != 300) begin errors++; $display("FAIL tput_sent got %0d exp 300", sent); end
    checks++; if (obs_out.size() != 300) begin errors++; $display("FAIL tput_popped got %0d exp 300", obs_out.size()); end
    checks++; if (last - first + 1 != 300) begin errors++; $display("FAIL tput_span got %0d cycles exp 300", last - first + 1); end
    checks++; if (bus.tx_count !== 8'd44) begin errors++; $display("FAIL tput_tx_count got %0d exp 44", bus.tx_count); end
    bad = 0;
    for (int i = 0; i < obs_out.size(); i++) if (obs_out[i] !== exp_out[i]) bad++;
    checks++; if (bad != 0) begin errors++; $display("FAIL tput_order got %0d out of order exp 0", bad); end
    clear_model();
  endtask

  task automatic test_random();
    for (int c = 0; c < 500; c++) begin
      bus.host_valid = $urandom_range(0, 1) == 1;
      bus.ring_busy  = $urandom_range(0, 2) == 0;
      bus.tx_ready   = $urandom_range(0, 3) != 0;
      rand_host();
      checks++; if (bus.host_ready !== (exp_fifo.size() < DEPTH)) begin errors++; $display("FAIL rnd_ready[%0d] got %b exp %b", c, bus.host_ready, exp_fifo.size() < DEPTH); end
      if (bus.tx_valid === 1'b1) begin
        checks++; if (exp_fifo.size() == 0 || bus.tx_instruction !== exp_fifo[0]) begin errors++; $display("FAIL rnd_head[%0d] got %h exp queued head", c, bus.tx_instruction); end
      end else begin
        checks++; if (bus.tx_instruction !== 32'h0 || bus.tx_source_port !== 2'b11) begin errors++; $display("FAIL rnd_idle_out[%0d] got %h/%b exp 0/11", c, bus.tx_instruction, bus.tx_source_port); end
      end
      tick();
    end
    bus.host_valid = 1'b0;
    bus.ring_busy  = 1'b0;
    bus.tx_ready   = 1'b1;
    for (int i = 0; i < 30 && (bus.tx_valid === 1'b1 || exp_fifo.size() > 0); i++) tick();
    checks++; if (exp_fifo.size() != 0) begin errors++; $display("FAIL rnd_drain got %0d left exp 0", exp_fifo.size()); end
    for (int i = 0; i < obs_out.size(); i++) begin
      checks++; if (obs_out[i] !== exp_out[i]) begin errors++; $display("FAIL rnd_order[%0d] got %h exp %h", i, obs_out[i], exp_out[i]); end
    end
    checks++; if (bus.tx_count !== 8'(hs_total)) begin errors++; $display("FAIL rnd_tx_count got %0d exp %0d", bus.tx_count, 8'(hs_total)); end
    clear_model();
  endtask

  initial begin
    test_reset();
    test_format();
    test_reset_mid();
    test_full();
    test_starve();
    test_hold();
    test_throughput();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog timeout at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule
